bpred_2bit_btb: RTL and testbench

- Parametrised successor to the single-global-bit branch predictor. Replaces the one shared prediction bit with a per-entry 2-bit saturating counter held in a direct-mapped, PC-indexed BTB.
- Sits between the IF stage (lookup) and the EX stage (resolution/update). Drives the PC mux with npc/hit and the pipeline flush with flush_br.
- Adds valid bits, synchronous reset, and branch/mispredict performance counters.

---
 rtl/bpred_2bit_btb.sv | 122 ++++++++++++
 tb/tb_bpred_2bit_btb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bpred_2bit_btb.sv
// rtl/bpred_2bit_btb.sv - direct-mapped BTB with per-entry 2-bit saturating counters
// IF-stage lookup, EX-stage resolution/training, flush/redirect and perf counters.
module bpred_2bit_btb #(
   parameter int          ENTRIES  = 16,
   parameter logic [1:0]  CNT_INIT = 2'b01,
   parameter int          PERF_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              predictor_en,
   input  logic [31:0]       pc_IF,
   input  logic [31:0]       instr_IF,
   input  logic [31:0]       pc_EX,
   input  logic [31:0]       instr_EX,
   input  logic              pc_sel_EX,
   input  logic [31:0]       aludata_EX,
   input  logic              pred_taken_EX,
   input  logic [31:0]       pred_target_EX,
   output logic              flush_br,
   output logic              hit,
   output logic [31:0]       npc,
   output logic [PERF_W-1:0] br_count,
   output logic [PERF_W-1:0] mispred_count
);

   localparam int               IDX_W     = $clog2(ENTRIES);
   localparam int               TAG_W     = 30 - IDX_W;
   localparam logic [6:0]       OP_BRANCH = 7'b1100011;
   localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [31:0]        r_target [ENTRIES];
   logic [1:0]         r_cnt    [ENTRIES];
   logic [PERF_W-1:0]  r_br_count;
   logic [PERF_W-1:0]  r_mispred_count;

   logic [IDX_W-1:0]   w_idx_if;
   logic [IDX_W-1:0]   w_idx_ex;
   logic [TAG_W-1:0]   w_tag_if;
   logic [TAG_W-1:0]   w_tag_ex;
   logic               w_is_br_if;
   logic               w_is_br_ex;
   logic               w_lookup_hit;
   logic               w_pred_taken;
   logic               w_train;
   logic               w_mispredict;
   logic               w_ex_match;

   assign w_idx_if     = pc_IF[IDX_W+1:2];
   assign w_idx_ex     = pc_EX[IDX_W+1:2];
   assign w_tag_if     = pc_IF[31:IDX_W+2];
   assign w_tag_ex     = pc_EX[31:IDX_W+2];
   assign w_is_br_if   = (instr_IF[6:0] == OP_BRANCH);
   assign w_is_br_ex   = (instr_EX[6:0] == OP_BRANCH);

   assign w_lookup_hit = predictor_en & w_is_br_if & r_valid[w_idx_if]
                         & (r_tag[w_idx_if] == w_tag_if);
   assign w_pred_taken = w_lookup_hit & r_cnt[w_idx_if][1];

   assign w_train      = predictor_en & w_is_br_ex;
   assign w_mispredict = w_train & ((pc_sel_EX != pred_taken_EX) |
                         (pc_sel_EX & pred_taken_EX & (pred_target_EX != aludata_EX)));
   assign w_ex_match   = r_valid[w_idx_ex] & (r_tag[w_idx_ex] == w_tag_ex);

   // EX correction always outranks the IF-stage prediction.
   always_comb begin
      flush_br = 1'b0;
      hit      = 1'b0;
      npc      = pc_IF + 32'd4;
      if (!rst_i) begin
         if (w_mispredict) begin
            flush_br = 1'b1;
            hit      = 1'b1;
            npc      = pc_sel_EX ? aludata_EX : (pc_EX + 32'd4);
         end else if (!predictor_en && w_is_br_ex && pc_sel_EX) begin
            flush_br = 1'b1;
            hit      = 1'b1;
            npc      = aludata_EX;
         end else if (w_pred_taken) begin
            hit      = 1'b1;
            npc      = r_target[w_idx_if];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_cnt[i]   <= CNT_INIT;
         end
         r_br_count      <= '0;
         r_mispred_count <= '0;
      end else begin
         if (w_train) begin
            r_br_count <= r_br_count + PERF_ONE;
            if (w_ex_match) begin
               if (pc_sel_EX) begin
                  if (r_cnt[w_idx_ex] != 2'b11)
                     r_cnt[w_idx_ex] <= r_cnt[w_idx_ex] + 2'd1;
                  r_target[w_idx_ex] <= aludata_EX;
               end else if (r_cnt[w_idx_ex] != 2'b00) begin
                  r_cnt[w_idx_ex] <= r_cnt[w_idx_ex] - 2'd1;
               end
            end else if (pc_sel_EX) begin
               // Taken miss replaces whatever occupied the slot, starting weakly taken.
               r_valid[w_idx_ex]  <= 1'b1;
               r_tag[w_idx_ex]    <= w_tag_ex;
               r_target[w_idx_ex] <= aludata_EX;
               r_cnt[w_idx_ex]    <= 2'b10;
            end
         end
         if (w_mispredict)
            r_mispred_count <= r_mispred_count + PERF_ONE;
      end
   end

   assign br_count      = r_br_count;
   assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_bpred_2bit_btb.sv
// tb/tb_bpred_2bit_btb.sv - directed table plus randomized model check of bpred_2bit_btb
module tb_bpred_2bit_btb;

   localparam logic [31:0] BR  = 32'h0000_0063;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        predictor_en;
   logic [31:0] pc_IF, instr_IF, pc_EX, instr_EX;
   logic        pc_sel_EX;
   logic [31:0] aludata_EX;
   logic        pred_taken_EX;
   logic [31:0] pred_target_EX;
   logic        flush_br, hit;
   logic [31:0] npc;
   logic [31:0] br_count, mispred_count;

   int n_vec = 0;
   int n_err = 0;

   bpred_2bit_btb #(.ENTRIES(16), .CNT_INIT(2'b01), .PERF_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .predictor_en(predictor_en),
      .pc_IF(pc_IF), .instr_IF(instr_IF), .pc_EX(pc_EX), .instr_EX(instr_EX),
      .pc_sel_EX(pc_sel_EX), .aludata_EX(aludata_EX),
      .pred_taken_EX(pred_taken_EX), .pred_target_EX(pred_target_EX),
      .flush_br(flush_br), .hit(hit), .npc(npc),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          rst, en;
      logic [31:0] pc_if, i_if, pc_ex, i_ex;
      bit          sel;
      logic [31:0] alu;
      bit          pt;
      logic [31:0] ptgt;
      bit          e_flush, e_hit;
      logic [31:0] e_npc, e_brc, e_mpc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit en, logic [31:0] pc_if, logic [31:0] i_if,
                               logic [31:0] pc_ex, logic [31:0] i_ex, bit sel,
                               logic [31:0] alu, bit pt, logic [31:0] ptgt,
                               bit e_flush, bit e_hit, logic [31:0] e_npc,
                               logic [31:0] e_brc, logic [31:0] e_mpc);
      vec_t v;
      v.rst = rst; v.en = en; v.pc_if = pc_if; v.i_if = i_if; v.pc_ex = pc_ex;
      v.i_ex = i_ex; v.sel = sel; v.alu = alu; v.pt = pt; v.ptgt = ptgt;
      v.e_flush = e_flush; v.e_hit = e_hit; v.e_npc = e_npc;
      v.e_brc = e_brc; v.e_mpc = e_mpc;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(bit rst, bit en, logic [31:0] pcif, logic [31:0] iif,
                        logic [31:0] pcex, logic [31:0] iex, bit sel,
                        logic [31:0] alu, bit pt, logic [31:0] ptgt);
      rst_i = rst; predictor_en = en; pc_IF = pcif; instr_IF = iif;
      pc_EX = pcex; instr_EX = iex; pc_sel_EX = sel; aludata_EX = alu;
      pred_taken_EX = pt; pred_target_EX = ptgt;
   endtask

   // Reference model: one record per BTB slot, counter kept as a plain 0..3 integer.
   typedef struct {
      bit          valid;
      int unsigned tag;
      logic [31:0] target;
      int          cnt;
   } ent_t;

   ent_t        m[16];
   int unsigned m_brc, m_mpc;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m[i].valid = 1'b0;
         m[i].cnt   = 1;
      end
      m_brc = 0;
      m_mpc = 0;
   endfunction

   initial begin
      drive(1, 1, 32'h0, NOP, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
      repeat (2) @(posedge clk_i);

      //     rst en pc_if      i_if pc_ex      i_ex sel alu        pt ptgt        fl hit npc        brc mpc
      tbl.push_back(mk(0,1, 32'h100,  BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,0, 32'h104,  0,0));
      tbl.push_back(mk(0,1, 32'h104,  NOP, 32'h100,  BR,  1, 32'h200, 0, 32'h104,  1,1, 32'h200,  0,0));
      tbl.push_back(mk(0,1, 32'h100,  BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,1, 32'h200,  1,1));
      tbl.push_back(mk(0,1, 32'h0,    NOP, 32'h100,  BR,  1, 32'h200, 1, 32'h200,  0,0, 32'h4,    1,1));
      tbl.push_back(mk(0,1, 32'h0,    NOP, 32'h100,  BR,  1, 32'h200, 1, 32'h200,  0,0, 32'h4,    2,1));
      tbl.push_back(mk(0,1, 32'h0,    NOP, 32'h100,  BR,  1, 32'h200, 1, 32'h200,  0,0, 32'h4,    3,1));
      tbl.push_back(mk(0,1, 32'h0,    NOP, 32'h100,  BR,  0, 32'h200, 1, 32'h200,  1,1, 32'h104,  4,1));
      tbl.push_back(mk(0,1, 32'h100,  BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,1, 32'h200,  5,2));
      tbl.push_back(mk(0,1, 32'h1100, BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,0, 32'h1104, 5,2));
      tbl.push_back(mk(0,1, 32'h0,    NOP, 32'h1100, BR,  1, 32'h300, 0, 32'h1104, 1,1, 32'h300,  5,2));
      tbl.push_back(mk(0,1, 32'h100,  BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,0, 32'h104,  6,3));
      tbl.push_back(mk(0,1, 32'h1100, BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,1, 32'h300,  6,3));
      tbl.push_back(mk(0,1, 32'h1100, BR,  32'h504,  BR,  1, 32'h600, 0, 32'h508,  1,1, 32'h600,  6,3));
      tbl.push_back(mk(0,0, 32'h1100, BR,  32'h700,  BR,  1, 32'h400, 0, 32'h704,  1,1, 32'h400,  7,4));
      tbl.push_back(mk(0,0, 32'h1100, BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,0, 32'h1104, 7,4));
      tbl.push_back(mk(0,1, 32'h1100, BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,1, 32'h300,  7,4));
      tbl.push_back(mk(0,1, 32'h1100, BR,  32'h1100, BR,  0, 32'h0,   0, 32'h1104, 0,1, 32'h300,  7,4));
      tbl.push_back(mk(0,1, 32'h1100, BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,0, 32'h1104, 8,4));
      tbl.push_back(mk(1,1, 32'h504,  BR,  32'h504,  BR,  0, 32'h0,   1, 32'h600,  0,0, 32'h508,  8,4));
      tbl.push_back(mk(0,1, 32'h504,  BR,  32'h0,    NOP, 0, 32'h0,   0, 32'h0,    0,0, 32'h508,  0,0));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk_i);
         drive(tbl[i].rst, tbl[i].en, tbl[i].pc_if, tbl[i].i_if, tbl[i].pc_ex,
               tbl[i].i_ex, tbl[i].sel, tbl[i].alu, tbl[i].pt, tbl[i].ptgt);
         #1;
         chk($sformatf("row%0d flush_br", i), {31'b0, flush_br}, {31'b0, tbl[i].e_flush});
         chk($sformatf("row%0d hit", i), {31'b0, hit}, {31'b0, tbl[i].e_hit});
         chk($sformatf("row%0d npc", i), npc, tbl[i].e_npc);
         chk($sformatf("row%0d br_count", i), br_count, tbl[i].e_brc);
         chk($sformatf("row%0d mispred_count", i), mispred_count, tbl[i].e_mpc);
      end

      @(negedge clk_i);
      drive(1, 1, 32'h0, NOP, 32'h0, NOP, 0, 32'h0, 0, 32'h0);
      model_reset();

      for (int c = 0; c < 3000; c++) begin
         bit          r_rst, r_en, r_sel, r_pt, br_if, br_ex, look, pt_if, mis;
         logic [31:0] r_pcif, r_pcex, r_alu, r_ptgt;
         int unsigned ii, ie;
         bit          e_fl, e_hit;
         logic [31:0] e_npc;

         @(negedge clk_i);
         r_rst  = ($urandom_range(0, 39) == 0);
         r_en   = ($urandom_range(0, 7) != 0);
         r_pcif = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         r_pcex = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         r_alu  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         br_if  = ($urandom_range(0, 3) != 0);
         br_ex  = ($urandom_range(0, 3) != 0);
         r_sel  = $urandom_range(0, 1);
         r_pt   = $urandom_range(0, 1);
         r_ptgt = ($urandom_range(0, 1) != 0) ? r_alu : $urandom;
         drive(r_rst, r_en, r_pcif, br_if ? BR : NOP, r_pcex, br_ex ? BR : NOP,
               r_sel, r_alu, r_pt, r_ptgt);

         ii    = (r_pcif >> 2) % 16;
         ie    = (r_pcex >> 2) % 16;
         look  = r_en && br_if && m[ii].valid && (m[ii].tag == (r_pcif >> 6));
         pt_if = look && (m[ii].cnt >= 2);
         mis   = r_en && br_ex && ((r_sel != r_pt) || (r_sel && r_pt && (r_ptgt != r_alu)));

         e_fl = 0; e_hit = 0; e_npc = r_pcif + 4;
         if (!r_rst) begin
            if (mis) begin
               e_fl = 1; e_hit = 1; e_npc = r_sel ? r_alu : r_pcex + 4;
            end else if (!r_en && br_ex && r_sel) begin
               e_fl = 1; e_hit = 1; e_npc = r_alu;
            end else if (pt_if) begin
               e_hit = 1; e_npc = m[ii].target;
            end
         end

         #1;
         chk($sformatf("rnd%0d flush_br", c), {31'b0, flush_br}, {31'b0, e_fl});
         chk($sformatf("rnd%0d hit", c), {31'b0, hit}, {31'b0, e_hit});
         chk($sformatf("rnd%0d npc", c), npc, e_npc);
         chk($sformatf("rnd%0d br_count", c), br_count, m_brc);
         chk($sformatf("rnd%0d mispred_count", c), mispred_count, m_mpc);

         if (r_rst) begin
            model_reset();
         end else if (r_en && br_ex) begin
            m_brc++;
            if (mis) m_mpc++;
            if (m[ie].valid && m[ie].tag == (r_pcex >> 6)) begin
               m[ie].cnt = r_sel ? ((m[ie].cnt < 3) ? m[ie].cnt + 1 : 3)
                                 : ((m[ie].cnt > 0) ? m[ie].cnt - 1 : 0);
               if (r_sel) m[ie].target = r_alu;
            end else if (r_sel) begin
               m[ie].valid  = 1;
               m[ie].tag    = r_pcex >> 6;
               m[ie].target = r_alu;
               m[ie].cnt    = 2;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
